// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Issues a single outstanding read to
//               instruction memory, holds the returned word with its address
//               until the consumer accepts it, then computes the next fetch
//               address (sequential or branch target).
//               Optional feature macro: IF_ALIGN_CHECK_EN. When defined, a
//               misaligned next fetch address traps into a sticky FAULT
//               state. When undefined, the low two address bits are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter logic [31:0] INITIAL_PC = 32'h00400000,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic [31:0] PC,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PCSrc,
   input  logic [31:0] branch_offset,
   output logic [31:0] instr_count,
   output logic        fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        imem_req_q, imem_req_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] w_next_pc;
   logic        w_accept;
`ifdef IF_ALIGN_CHECK_EN
   logic        fault_q, fault_d;
`endif

   // Candidate next fetch address; only used in the acceptance cycle.
   always_comb begin
      w_accept  = instr_valid_q & instr_ready;
      w_next_pc = PCSrc ? (pc_q + branch_offset) : (pc_q + 32'd4);
   end

   // Next-state and registered-output computation for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_count_d = instr_count_q;
      imem_req_d    = imem_req_q;
      instr_valid_d = instr_valid_q;
`ifdef IF_ALIGN_CHECK_EN
      fault_d       = fault_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Any ack seen here belongs to an abandoned request; ignore it.
            state_d    = S_REQ;
            imem_req_d = 1'b1;
         end
         S_REQ: begin
            if (imem_ack) begin
               instr_d       = imem_rdata;
               pc_d          = fetch_pc_q;
               state_d       = S_VALID;
               imem_req_d    = 1'b0;
               instr_valid_d = 1'b1;
            end
         end
         S_VALID: begin
            if (w_accept) begin
               instr_count_d = instr_count_q + 32'd1;
               instr_d       = NOP_INSTR;
               instr_valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
               if (w_next_pc[1:0] != 2'b00) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end else begin
                  state_d    = S_REQ;
                  imem_req_d = 1'b1;
                  fetch_pc_d = w_next_pc;
               end
`else
               state_d    = S_REQ;
               imem_req_d = 1'b1;
               fetch_pc_d = w_next_pc & ~32'd3;
`endif
            end
         end
         S_FAULT: begin
            // Sticky until reset.
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= INITIAL_PC;
         pc_q          <= INITIAL_PC;
         instr_q       <= NOP_INSTR;
         instr_count_q <= 32'd0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_count_q <= instr_count_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
`ifdef IF_ALIGN_CHECK_EN
         fault_q       <= fault_d;
`endif
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign imem_req    = imem_req_q;
   assign instr       = instr_q;
   assign PC          = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr_count = instr_count_q;
`ifdef IF_ALIGN_CHECK_EN
   assign fault       = fault_q;
`else
   assign fault       = 1'b0;
`endif

endmodule
`default_nettype wire
